gray_serial_codec: RTL and testbench

- Bit-serial companion to the team's parallel Gray/binary converter (`gtbtg`).
- Accepts an N-bit word one bit per cycle, MSB first, and converts it bit-serially in the direction selected by `mode`:
  - mode=1: Gray to binary.
  - mode=0: binary to Gray.
- Emits each converted bit as it is produced, then presents the assembled parallel word with a done pulse.
- Sits on narrow serial links whose far end uses the parallel converter.

---
 rtl/gray_serial_codec.sv | 103 ++++++++++
 tb/tb_gray_serial_codec.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/gray_serial_codec.sv
// Bit-serial Gray<->binary codec, MSB first, with parallel word output.
// Optional abort path enabled by defining GRAY_SER_ABORT_EN.
module gray_serial_codec #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         mode,
   input  logic         start,
   input  logic         bit_valid,
   input  logic         bit_in,
`ifdef GRAY_SER_ABORT_EN
   input  logic         abort,
   output logic         aborted,
`endif
   output logic         bit_out,
   output logic         bit_out_valid,
   output logic [N-1:0] y,
   output logic         done,
   output logic         busy
);

   localparam int CW = (N > 2) ? $clog2(N) : 1;

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   logic [0:0]    state_q;
   logic [CW-1:0] cnt_q;
   logic          h_q;
   logic          mode_q;
   logic [N-1:0]  sh_q;
   logic          conv;
   logic          take;
   logic          stop;

   // converted bit for the current input, same XOR in both directions
   always_comb begin
      conv = h_q ^ bit_in;
      take = (state_q == SHIFT) && bit_valid;
`ifdef GRAY_SER_ABORT_EN
      stop = (state_q == SHIFT) && abort;
`else
      stop = 1'b0;
`endif
   end

   // control FSM, history bit, shift register and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         h_q           <= 1'b0;
         mode_q        <= 1'b0;
         sh_q          <= '0;
         bit_out       <= 1'b0;
         bit_out_valid <= 1'b0;
         y             <= '0;
         done          <= 1'b0;
         busy          <= 1'b0;
`ifdef GRAY_SER_ABORT_EN
         aborted       <= 1'b0;
`endif
      end else if (en) begin
         bit_out_valid <= 1'b0;
         done          <= 1'b0;
`ifdef GRAY_SER_ABORT_EN
         aborted       <= 1'b0;
`endif
         if (state_q == IDLE) begin
            if (start) begin
               mode_q  <= mode;
               h_q     <= 1'b0;
               cnt_q   <= CW'(N - 1);
               state_q <= SHIFT;
               busy    <= 1'b1;
            end
         end else if (stop) begin
            // word dropped: y and the history are left as they are
            state_q <= IDLE;
            busy    <= 1'b0;
`ifdef GRAY_SER_ABORT_EN
            aborted <= 1'b1;
`endif
         end else if (take) begin
            h_q           <= mode_q ? conv : bit_in;
            bit_out       <= conv;
            bit_out_valid <= 1'b1;
            sh_q          <= {sh_q[N-2:0], conv};
            if (cnt_q == '0) begin
               y       <= {sh_q[N-2:0], conv};
               done    <= 1'b1;
               busy    <= 1'b0;
               state_q <= IDLE;
            end else begin
               cnt_q <= cnt_q - 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_gray_serial_codec.sv
// Scoreboard bench for gray_serial_codec (N=8).
// Expected words/bits are queued at issue, checked by a monitor.
module tb_gray_serial_codec;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       mode;
   logic       start;
   logic       bit_valid;
   logic       bit_in;
   logic       bit_out;
   logic       bit_out_valid;
   logic [7:0] y;
   logic       done;
   logic       busy;
`ifdef GRAY_SER_ABORT_EN
   logic       abort;
   logic       aborted;
`endif

   int ntests = 0;
   int nfail  = 0;
   int nstrobe = 0;
   int ndone   = 0;
   int nwords  = 0;

   logic [7:0] yq[$];
   logic       bq[$];

   gray_serial_codec #(.N(8)) dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .mode(mode),
      .start(start),
      .bit_valid(bit_valid),
      .bit_in(bit_in),
`ifdef GRAY_SER_ABORT_EN
      .abort(abort),
      .aborted(aborted),
`endif
      .bit_out(bit_out),
      .bit_out_valid(bit_out_valid),
      .y(y),
      .done(done),
      .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: run did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] b2g(input logic [7:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [7:0] g2b(input logic [7:0] g);
      logic [7:0] b;
      b[7] = g[7];
      for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   // monitor: compare serial bits and completed words as they appear
   always @(negedge clk) begin
      if (bit_out_valid === 1'b1) begin
         nstrobe++;
         if (bq.size() == 0) check("unexpected_strobe", 1, 0);
         else check("bit_out", bit_out, bq.pop_front());
      end
      if (done === 1'b1) begin
         ndone++;
         if (yq.size() == 0) check("unexpected_done", 1, 0);
         else check("y", y, yq.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [7:0] w);
      yq.push_back(w);
      for (int i = 7; i >= 0; i--) bq.push_back(w[i]);
      nwords++;
   endtask

   task automatic send_word(input logic m, input logic [7:0] w,
                            input bit toggle);
      mode  = m;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         bit_valid = 1'b1;
         bit_in    = w[i];
         if (toggle) mode = ~mode;
         tick();
      end
      bit_valid = 1'b0;
   endtask

   initial begin
      int s0;
      int busy_bad;
      logic [7:0] v;
      rst = 1'b1; en = 1'b1; mode = 1'b0; start = 1'b0;
      bit_valid = 1'b0; bit_in = 1'b0;
`ifdef GRAY_SER_ABORT_EN
      abort = 1'b0;
`endif
      tick(); tick();
      rst = 1'b0;
      check("rst_y", y, 0);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      check("rst_bit_out", bit_out, 0);
      check("rst_bov", bit_out_valid, 0);

      // Gray FF -> AA, explicit bit pattern
      yq.push_back(8'hAA);
      for (int i = 0; i < 8; i++) bq.push_back(i[0] ? 1'b0 : 1'b1);
      nwords++;
      send_word(1'b1, 8'hFF, 0);
      check("done_cycle_busy", busy, 0);
      tick(); tick();

      // back-to-back words, start in the done cycle
      s0 = ndone;
      push_exp(8'hFF); send_word(1'b0, 8'hAA, 0);
      push_exp(8'h80); send_word(1'b1, 8'hC0, 0);
      push_exp(8'hC0); send_word(1'b0, 8'h80, 0);
      tick();
      check("b2b_dones", ndone - s0, 3);
      tick();

      // gaps and en=0 stalls
      s0 = nstrobe;
      busy_bad = 0;
      push_exp(8'hAA);
      mode = 1'b1; start = 1'b1; tick(); start = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         int k;
         k = $urandom_range(1, 3);
         for (int j = 0; j < k; j++) begin
            if (busy !== 1'b1) busy_bad++;
            tick();
         end
         en = 1'b0; bit_valid = 1'b1; bit_in = 1'b0; start = 1'b1;
         tick(); tick();
         if (busy !== 1'b1) busy_bad++;
         en = 1'b1; start = 1'b0; bit_in = 1'b1;
         tick();
         bit_valid = 1'b0;
      end
      tick();
      check("gap_strobes", nstrobe - s0, 8);
      check("gap_busy", busy_bad, 0);
      tick();

      // full sweep, mode toggled mid-word
      for (int n = 0; n < 256; n++) begin
         v = n[7:0];
         push_exp(g2b(v)); send_word(1'b1, v, v[0]);
         push_exp(b2g(v)); send_word(1'b0, v, v[1]);
      end
      tick(); tick();

      // reset after the 4th bit
      bq.push_back(1'b1); bq.push_back(1'b0);
      bq.push_back(1'b1); bq.push_back(1'b0);
      mode = 1'b1; start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bit_valid = 1'b1; bit_in = 1'b1; tick();
      end
      bit_valid = 1'b0;
      rst = 1'b1; tick(); rst = 1'b0;
      check("midrst_y", y, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      tick();
      push_exp(8'h00); send_word(1'b1, 8'h00, 0);
      tick(); tick();

`ifdef GRAY_SER_ABORT_EN
      push_exp(8'hAA); send_word(1'b1, 8'hFF, 0);
      tick(); tick();
      for (int i = 0; i < 5; i++) bq.push_back(i[0] ? 1'b0 : 1'b1);
      s0 = ndone;
      mode = 1'b1; start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bit_valid = 1'b1; bit_in = 1'b1;
         if (i == 2) begin start = 1'b1; mode = 1'b0; end
         tick();
         start = 1'b0;
      end
      abort = 1'b1; bit_valid = 1'b1; tick();
      abort = 1'b0; bit_valid = 1'b0;
      check("abort_pulse", aborted, 1);
      check("abort_busy", busy, 0);
      check("abort_y", y, 8'hAA);
      check("abort_bov", bit_out_valid, 0);
      tick();
      check("abort_clear", aborted, 0);
      abort = 1'b1; tick(); abort = 1'b0;
      check("abort_idle", aborted, 0);
      check("abort_nodone", ndone - s0, 0);
      tick();
`endif

      tick(); tick();
      check("words_done", ndone, nwords);
      check("yq_empty", yq.size(), 0);
      check("bq_empty", bq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
